// File: rtl/btb_unit.sv
// btb_unit: direct-mapped branch target buffer.
//   Fetch presents lookup_pc_i each cycle; the prediction comes back one
//   cycle later, aligned with the synchronous instruction-memory read.
//   Execute drives resolved branches on upd_*; writes commit on the same edge.
//   After reset, and on flush_i, a sweep invalidates one entry per cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   lookup_valid_i/_pc_i      fetch lookup request
//   hit_o, pred_taken_o,
//   pred_target_o, entry_pc_o registered lookup result
//   upd_valid_i/_pc_i/
//   _target_i/_taken_i        resolved-branch update
//   flush_i                   full-table invalidate request
//   busy_o                    sweep in progress
module btb_unit #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic [31:0] entry_pc_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_taken_i,
  input  logic        flush_i,
  output logic        busy_o
);

  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_cnt;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_match, upd_match;
  logic             unused_pc_bits;

  assign lkp_idx = lookup_pc_i[IDX_W+1:2];
  assign lkp_tag = lookup_pc_i[31:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[31:IDX_W+2];

  // Both ports read the table before this edge's write (read-before-write).
  assign lkp_match = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign busy_o = (state == SWEEP);

  // Byte-offset bits of the update PC carry no information for word-aligned code.
  assign unused_pc_bits = ^upd_pc_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SWEEP;
      sweep_cnt     <= '0;
      hit_o         <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
      entry_pc_o    <= '0;
    end else begin
      // Lookup result: a miss unless a valid request hits while idle.
      hit_o         <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
      if (lookup_valid_i) begin
        entry_pc_o <= lookup_pc_i;
        if (state == IDLE && lkp_match) begin
          hit_o         <= 1'b1;
          pred_taken_o  <= ctr_q[lkp_idx][1];
          pred_target_o <= target_q[lkp_idx];
        end
      end

      case (state)
        SWEEP: begin
          // The sweep owns the write port; updates and flushes are ignored.
          valid_q[sweep_cnt] <= 1'b0;
          ctr_q[sweep_cnt]   <= 2'b01;
          sweep_cnt          <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_IDX) state <= IDLE;
        end
        default: begin
          if (upd_valid_i) begin
            if (upd_match) begin
              if (upd_taken_i) begin
                if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                target_q[upd_idx] <= upd_target_i;
              end else if (ctr_q[upd_idx] != 2'b00) begin
                ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
              end
            end else if (upd_taken_i) begin
              valid_q[upd_idx]  <= 1'b1;
              tag_q[upd_idx]    <= upd_tag;
              target_q[upd_idx] <= upd_target_i;
              ctr_q[upd_idx]    <= 2'b10;
            end
          end
          if (flush_i) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_unit.sv
module tb_btb_unit;

  localparam int ENTRIES = 16;

  logic        clk;
  logic        rst;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [31:0] entry_pc_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic        flush_i;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  btb_unit #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .hit_o(hit_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .entry_pc_o(entry_pc_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Table keyed by index; the sweep is modelled as an instant full clear
  // plus a count of remaining busy cycles (entries are invisible meanwhile).
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_rem = 0;

  logic        e_hit, e_taken, e_busy;
  logic [31:0] e_target, e_entry;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
  endtask

  always @(posedge clk) begin
    int li, ui;
    bit sweeping;
    if (rst) begin
      m_clear();
      m_rem    = ENTRIES;
      e_hit    = 0; e_taken = 0; e_target = 0; e_entry = 0;
    end else begin
      sweeping = (m_rem > 0);
      li = idx_of(lookup_pc_i);
      e_hit = 0; e_taken = 0; e_target = 0;
      if (lookup_valid_i) begin
        e_entry = lookup_pc_i;
        if (!sweeping && m_valid[li] && m_tag[li] == tag_of(lookup_pc_i)) begin
          e_hit    = 1;
          e_taken  = (m_ctr[li] >= 2);
          e_target = m_target[li];
        end
      end
      if (sweeping) begin
        m_rem = m_rem - 1;
      end else begin
        if (upd_valid_i) begin
          ui = idx_of(upd_pc_i);
          if (m_valid[ui] && m_tag[ui] == tag_of(upd_pc_i)) begin
            if (upd_taken_i) begin
              if (m_ctr[ui] < 3) m_ctr[ui] = m_ctr[ui] + 1;
              m_target[ui] = upd_target_i;
            end else if (m_ctr[ui] > 0) begin
              m_ctr[ui] = m_ctr[ui] - 1;
            end
          end else if (upd_taken_i) begin
            m_valid[ui]  = 1;
            m_tag[ui]    = tag_of(upd_pc_i);
            m_target[ui] = upd_target_i;
            m_ctr[ui]    = 2;
          end
        end
        if (flush_i) begin
          m_clear();
          m_rem = ENTRIES;
        end
      end
    end
    e_busy = (m_rem > 0);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (hit_o !== e_hit || pred_taken_o !== e_taken || pred_target_o !== e_target ||
          entry_pc_o !== e_entry || busy_o !== e_busy) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got hit=%b tk=%b tgt=%h pc=%h busy=%b, expected hit=%b tk=%b tgt=%h pc=%h busy=%b",
                 $time, hit_o, pred_taken_o, pred_target_o, entry_pc_o, busy_o,
                 e_hit, e_taken, e_target, e_entry, e_busy);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    rst = 0; lookup_valid_i = 0; lookup_pc_i = 0; upd_valid_i = 0;
    upd_pc_i = 0; upd_target_i = 0; upd_taken_i = 0; flush_i = 0;
  endtask

  // One cycle: drive at negedge, advance to the next negedge.
  task automatic cyc(input bit lv, input logic [31:0] lpc,
                     input bit uv, input logic [31:0] upc, input logic [31:0] utg, input bit ut,
                     input bit fl, input bit r);
    lookup_valid_i = lv; lookup_pc_i = lpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_target_i = utg; upd_taken_i = ut;
    flush_i = fl; rst = r;
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1, pc, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input bit t);
    cyc(0, 0, 1, pc, tg, t, 0, 0);
  endtask

  // Counts busy cycles starting at the current (already busy) cycle.
  task automatic count_busy(input string name, input bit do_upd);
    int n;
    n = busy_o ? 1 : 0;
    for (int i = 0; i < 40 && busy_o; i++) begin
      cyc(1, 32'h100, do_upd, 32'h100, 32'h500, 1, 0, 0);
      if (busy_o) n++;
      chk({name, "_hit"}, {31'd0, hit_o}, 0);
    end
    chk(name, n, ENTRIES);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc_a, pc_b;
    idle_in();
    rst = 1;
    @(negedge clk);
    chk_en = 1;
    chk("rst_hit", {31'd0, hit_o}, 0);
    chk("rst_tk", {31'd0, pred_taken_o}, 0);
    chk("rst_tgt", pred_target_o, 0);
    chk("rst_pc", entry_pc_o, 0);
    chk("rst_busy", {31'd0, busy_o}, 1);
    count_busy("rst_busy_len", 0);
    look(32'h100);
    chk("post_sweep_miss", {31'd0, hit_o}, 0);

    upd(32'h100, 32'h200, 1);
    look(32'h100);
    chk("alloc_hit", {31'd0, hit_o}, 1);
    chk("alloc_tk", {31'd0, pred_taken_o}, 1);
    chk("alloc_tgt", pred_target_o, 32'h200);
    chk("alloc_pc", entry_pc_o, 32'h100);

    upd(32'h100, 0, 0);
    upd(32'h100, 0, 0);
    look(32'h100);
    chk("nt2_hit", {31'd0, hit_o}, 1);
    chk("nt2_tk", {31'd0, pred_taken_o}, 0);
    upd(32'h100, 0, 0);
    look(32'h100);
    chk("nt_floor_hit", {31'd0, hit_o}, 1);
    upd(32'h100, 32'h200, 1);
    look(32'h100);
    chk("ctr01_tk", {31'd0, pred_taken_o}, 0);
    upd(32'h100, 32'h200, 1);
    upd(32'h100, 32'h200, 1);
    upd(32'h100, 32'h200, 1);
    look(32'h100);
    chk("sat_tk", {31'd0, pred_taken_o}, 1);
    upd(32'h100, 0, 0);
    look(32'h100);
    chk("sat_then_nt_tk", {31'd0, pred_taken_o}, 1);

    look(32'h140);
    chk("alias_miss", {31'd0, hit_o}, 0);
    upd(32'h140, 32'h300, 1);
    look(32'h100);
    chk("replaced_miss", {31'd0, hit_o}, 0);
    look(32'h140);
    chk("replace_hit", {31'd0, hit_o}, 1);
    chk("replace_tgt", pred_target_o, 32'h300);

    upd(32'h100, 32'h200, 1);
    cyc(1, 32'h100, 1, 32'h100, 32'h400, 1, 0, 0);
    chk("rbw_old", pred_target_o, 32'h200);
    look(32'h100);
    chk("rbw_new", pred_target_o, 32'h400);

    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    count_busy("flush_busy_len", 1);
    look(32'h100);
    chk("post_flush_miss", {31'd0, hit_o}, 0);

    upd(32'h100, 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    count_busy("rst_mid_sweep_len", 0);

    // randomized traffic over a few tags so hits, aliases and updates collide
    for (int n = 0; n < 4000; n++) begin
      pc_a = {24'(($urandom % 4) == 3 ? $urandom : $urandom % 3), 8'h0} >> 2;
      pc_a = (($urandom % 3) << 6) | (($urandom % ENTRIES) << 2);
      pc_b = (($urandom % 3) << 6) | (($urandom % ENTRIES) << 2);
      if ($urandom % 8 == 0) pc_b = $urandom & 32'hFFFF_FFFC;
      cyc(($urandom % 10) < 7, pc_a,
          ($urandom % 10) < 5, pc_b, $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0,
          ($urandom % 300) == 0, ($urandom % 700) == 0);
    end

    idle_in();
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
